led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Step scheduler for the LED chaser datapath.
- Consumes the 2-bit speed/pause status from the front-panel controller (0 low, 1 mid, 2 high, 3 pause).
- Generates a per-speed step tick from the system clock and advances a single-lit LED position in bounce or rotate mode.
- Sits between the button controller and the board LED pins. All outputs are registered.

Parameters:
- P_LOW, 50_000_000, clock cycles per step at low speed (status 0)
- P_MID, 25_000_000, clock cycles per step at mid speed (status 1)
- P_HIGH, 10_000_000, clock cycles per step at high speed (status 2)
- N_LED, 8, number of LEDs. Legal range is N_LED >= 2.
- Legality rule: P_LOW >= P_MID >= P_HIGH >= 1. Divider width DW = max(1, $clog2(P_LOW)). Position width PW = $clog2(N_LED).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- status  in  2  0 low, 1 mid, 2 high, 3 pause; sampled every edge
- mode  in  1  0 bounce (ping-pong), 1 rotate (wrap-around)
- led  out  N_LED  one-hot LED drive; led[pos] = 1
- pos  out  PW  current lit index
- dir  out  1  0 = moving toward MSB, 1 = moving toward LSB
- step_tick  out  1  one-cycle pulse, high in the cycle the new led/pos first appears
- running  out  1  registered (status != 3)

Behaviour:
- One clock domain (clk). Asynchronous active-low reset (rst_n).
- Reset values (asynchronous): div_cnt=0, pos=0, led=1 (bit 0 lit), dir=0, step_tick=0, running=0.
- Period select: per = P_LOW / P_MID / P_HIGH for status 0/1/2. Status 3 means pause. All four codes are defined.
- Every edge, running <= (status != 3).
- Paused (status==3):
  - div_cnt, pos, led and dir hold.
  - step_tick <= 0.
  - On resume, counting continues from the held div_cnt; no restart.
- Not paused, div_cnt < per-1: div_cnt <= div_cnt+1; step_tick <= 0.
- Not paused, div_cnt >= per-1: this is a step.
  - div_cnt <= 0; step_tick <= 1.
  - pos, dir and led update on the same edge.
  - The compare must be >=, not ==. This covers a speed-up mid-period where div_cnt already exceeds the new per-1: the step fires on the next edge.
- Speed-down mid-period: div_cnt keeps counting up to the new per-1. No early step.
- P=1 gives a step every cycle, with step_tick held high continuously.
- Bounce step (mode=0):
  - dir=0: if pos==N_LED-1 then dir<=1, pos<=N_LED-2; else pos<=pos+1.
  - dir=1: if pos==0 then dir<=0, pos<=1; else pos<=pos-1.
  - The end LEDs are lit for exactly one step each. Sequence period is 2*(N_LED-1) steps.
- Rotate step (mode=1):
  - dir<=0.
  - pos<=(pos==N_LED-1) ? 0 : pos+1.
- Mode changes are sampled only at a step edge; no effect between steps. Bounce with dir=1 switched to rotate: the next step goes upward from the current pos.
- led is always the one-hot of pos. The led register and pos register update on the same edge and never disagree. led is never all-zero and never multi-hot.
- Reset mid-operation (rst_n low at any time): all registers return to reset values immediately, independent of clk. After release, the first step occurs per cycles later.
- No arithmetic overflow: div_cnt never exceeds P_LOW-1. pos stays in the range 0..N_LED-1.

Test Plan:
All tests use P_LOW=8, P_MID=4, P_HIGH=2, N_LED=8.
1. Reset release, status=1, mode=0 -> first step_tick after the 4th rising edge; led 0x01→0x02. step_tick then repeats every 4 cycles; running=1 from the 1st edge.
2. Bounce, status=2, run 16 steps from reset -> pos sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2. dir rises at pos 7→6 and falls at 0→1. led is always one-hot.
3. status=0 until div_cnt=5, then status=2 -> step on the very next edge; subsequent steps every 2 cycles. Reverse case: div_cnt=1 at high, switch to low -> next step 7 edges later.
4. status=3 for 20 cycles mid-period with div_cnt=2 at mid speed -> led/pos/dir frozen, step_tick=0, running=0. Return to status=1 -> step 2 edges after resume.
5. mode=1 from pos=6 -> steps give pos 7,0,1 with dir=0. Switch mode=1 while bouncing at pos=5 with dir=1 -> next pos is 6, dir=0.
6. Assert rst_n low between edges at pos=5, div_cnt=3 -> outputs go to reset values immediately, asynchronous to clk. After release, behaviour matches test 1.

Source files
------------

// File: rtl/led_sequencer_if.sv
// Signal bundle between the front-panel controller side and the LED step
// scheduler: speed/pause status and mode in, LED position and status out.
interface led_sequencer_if #(
    parameter int N_LED = 8
);

    localparam int PW = $clog2(N_LED);

    logic [1:0]       status;     // 0 low, 1 mid, 2 high, 3 pause
    logic             mode;       // 0 bounce, 1 rotate
    logic [N_LED-1:0] led;        // one-hot LED drive
    logic [PW-1:0]    pos;        // index of the lit LED
    logic             dir;        // 0 toward MSB, 1 toward LSB
    logic             step_tick;  // pulse in the cycle a new position appears
    logic             running;    // registered (status != 3)

    // Controller side: drives status/mode and observes the sequencer state
    modport master (
        output status,
        output mode,
        input  led,
        input  pos,
        input  dir,
        input  step_tick,
        input  running
    );

    // Sequencer side: consumes status/mode and drives the LED outputs
    modport slave (
        input  status,
        input  mode,
        output led,
        output pos,
        output dir,
        output step_tick,
        output running
    );

endinterface

// File: rtl/led_sequencer.sv
// LED chaser step scheduler. A free-running divider produces a step every
// P_LOW/P_MID/P_HIGH clocks depending on the 2-bit status (3 = pause), and
// each step moves a single lit LED in bounce (ping-pong) or rotate mode.
// All outputs come straight from registers.
module led_sequencer #(
    parameter int P_LOW  = 50_000_000,
    parameter int P_MID  = 25_000_000,
    parameter int P_HIGH = 10_000_000,
    parameter int N_LED  = 8
) (
    input logic             clk,
    input logic             rst_n,
    led_sequencer_if.slave  bus
);

    localparam int DW = (P_LOW > 1) ? $clog2(P_LOW) : 1;
    localparam int PW = $clog2(N_LED);

    // Terminal divider counts (period minus one) for each speed
    localparam logic [DW-1:0] C_LOW_M1  = DW'(P_LOW  - 1);
    localparam logic [DW-1:0] C_MID_M1  = DW'(P_MID  - 1);
    localparam logic [DW-1:0] C_HIGH_M1 = DW'(P_HIGH - 1);

    localparam logic [PW-1:0]    C_POS_LAST = PW'(N_LED - 1);
    localparam logic [PW-1:0]    C_POS_PREV = PW'(N_LED - 2);
    localparam logic [PW-1:0]    C_POS_ONE  = PW'(1);
    localparam logic [N_LED-1:0] C_LED_ONE  = N_LED'(1);

    // Direction of travel; DIR_UP moves toward the MSB LED
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [DW-1:0]    r_div_cnt;
    logic [PW-1:0]    r_pos;
    logic [N_LED-1:0] r_led;
    dir_e             r_dir;
    logic             r_step_tick;
    logic             r_running;

    logic             w_pause;
    logic [DW-1:0]    w_per_m1;
    logic             w_step;
    logic [DW-1:0]    w_div_nxt;
    logic [PW-1:0]    w_pos_nxt;
    dir_e             w_dir_nxt;
    logic [N_LED-1:0] w_led_nxt;

    // Decode the period for the current speed and detect a step edge.
    // The >= compare lets a speed-up mid-period step on the very next edge
    // when the count already exceeds the new terminal value.
    always_comb begin
        w_pause  = (bus.status == 2'd3);
        w_per_m1 = C_LOW_M1;
        case (bus.status)
            2'd0:    w_per_m1 = C_LOW_M1;
            2'd1:    w_per_m1 = C_MID_M1;
            2'd2:    w_per_m1 = C_HIGH_M1;
            default: w_per_m1 = C_LOW_M1;
        endcase
        w_step = !w_pause && (r_div_cnt >= w_per_m1);
    end

    // Next divider count: hold while paused, clear on a step, else count up
    always_comb begin
        w_div_nxt = r_div_cnt;
        if (w_pause) begin
            w_div_nxt = r_div_cnt;
        end else if (w_step) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div_cnt + DW'(1);
        end
    end

    // Next position/direction: only a step edge moves the LED, and mode is
    // looked at only here so switching between steps has no visible effect
    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (w_step) begin
            if (bus.mode) begin
                w_dir_nxt = DIR_UP;
                w_pos_nxt = (r_pos == C_POS_LAST) ? '0 : r_pos + C_POS_ONE;
            end else if (r_dir == DIR_UP) begin
                if (r_pos == C_POS_LAST) begin
                    w_dir_nxt = DIR_DOWN;
                    w_pos_nxt = C_POS_PREV;
                end else begin
                    w_pos_nxt = r_pos + C_POS_ONE;
                end
            end else begin
                if (r_pos == '0) begin
                    w_dir_nxt = DIR_UP;
                    w_pos_nxt = C_POS_ONE;
                end else begin
                    w_pos_nxt = r_pos - C_POS_ONE;
                end
            end
        end
    end

    // LED pattern is derived from the next position so led and pos are
    // loaded on the same edge and can never disagree
    always_comb begin
        w_led_nxt = C_LED_ONE << w_pos_nxt;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_pos       <= '0;
            r_led       <= C_LED_ONE;
            r_dir       <= DIR_UP;
            r_step_tick <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_div_cnt   <= w_div_nxt;
            r_pos       <= w_pos_nxt;
            r_led       <= w_led_nxt;
            r_dir       <= w_dir_nxt;
            r_step_tick <= w_step;
            r_running   <= !w_pause;
        end
    end

    assign bus.led       = r_led;
    assign bus.pos       = r_pos;
    assign bus.dir       = r_dir;
    assign bus.step_tick = r_step_tick;
    assign bus.running   = r_running;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with P_LOW=8, P_MID=4, P_HIGH=2, N_LED=8.
module tb_led_sequencer;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    led_sequencer_if #(.N_LED(8)) bus ();

    led_sequencer #(
        .P_LOW  (8),
        .P_MID  (4),
        .P_HIGH (2),
        .N_LED  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed outputs packed as {led, pos, dir, step_tick, running}
    logic [13:0] obs;
    assign obs = {bus.led, bus.pos, bus.dir, bus.step_tick, bus.running};

    function automatic logic [13:0] mk_exp(input int p, input logic d,
                                           input logic t, input logic r);
        logic [7:0] l;
        logic [2:0] pp;
        pp = 3'(p);
        l  = 8'd1 << pp;
        return {l, pp, d, t, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] s, input logic m);
        @(negedge clk);
        rst_n = 1'b0;
        bus.status = s;
        bus.mode   = m;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.status = 2'd1;
        bus.mode   = 1'b0;
        #2;
        tests++;
        if (obs !== mk_exp(0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_assert got %h expected %h", obs, mk_exp(0, 0, 0, 0));
        end
        @(negedge clk);
        tests++;
        if (obs !== mk_exp(0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_held got %h expected %h", obs, mk_exp(0, 0, 0, 0));
        end
        rst_n = 1'b1;
    endtask

    // Shared by the first-step test and the post-async-reset check
    task automatic run_first_steps(input string name);
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++;
            if (obs !== mk_exp(0, 0, 0, 1)) begin
                fails++;
                $display("FAIL %s edge%0d got %h expected %h", name, e, obs, mk_exp(0, 0, 0, 1));
            end
        end
        tick();
        tests++;
        if (obs !== mk_exp(1, 0, 1, 1)) begin
            fails++;
            $display("FAIL %s first_step got %h expected %h", name, obs, mk_exp(1, 0, 1, 1));
        end
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < 3; e++) begin
                tick();
                tests++;
                if (obs !== mk_exp(k + 1, 0, 0, 1)) begin
                    fails++;
                    $display("FAIL %s idle k%0d e%0d got %h expected %h", name, k, e, obs, mk_exp(k + 1, 0, 0, 1));
                end
            end
            tick();
            tests++;
            if (obs !== mk_exp(k + 2, 0, 1, 1)) begin
                fails++;
                $display("FAIL %s step k%0d got %h expected %h", name, k, obs, mk_exp(k + 2, 0, 1, 1));
            end
        end
    endtask

    task automatic test_first_step();
        apply_reset(2'd1, 1'b0);
        run_first_steps("first_step");
    endtask

    task automatic test_bounce();
        int exp_pos [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        logic exp_dir [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int prev_pos;
        logic prev_dir;
        apply_reset(2'd2, 1'b0);
        prev_pos = 0;
        prev_dir = 1'b0;
        for (int s = 0; s < 16; s++) begin
            tick();
            tests++;
            if (obs !== mk_exp(prev_pos, prev_dir, 0, 1)) begin
                fails++;
                $display("FAIL bounce_idle s%0d got %h expected %h", s, obs, mk_exp(prev_pos, prev_dir, 0, 1));
            end
            tick();
            tests++;
            if (obs !== mk_exp(exp_pos[s], exp_dir[s], 1, 1)) begin
                fails++;
                $display("FAIL bounce_step s%0d got %h expected %h", s, obs, mk_exp(exp_pos[s], exp_dir[s], 1, 1));
            end
            prev_pos = exp_pos[s];
            prev_dir = exp_dir[s];
        end
    endtask

    task automatic test_speed_change();
        apply_reset(2'd0, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            tick();
            tests++;
            if (obs !== mk_exp(0, 0, 0, 1)) begin
                fails++;
                $display("FAIL speedup_count e%0d got %h expected %h", e, obs, mk_exp(0, 0, 0, 1));
            end
        end
        bus.status = 2'd2;
        tick();
        tests++;
        if (obs !== mk_exp(1, 0, 1, 1)) begin
            fails++;
            $display("FAIL speedup_step got %h expected %h", obs, mk_exp(1, 0, 1, 1));
        end
        tick();
        tests++;
        if (obs !== mk_exp(1, 0, 0, 1)) begin
            fails++;
            $display("FAIL speedup_idle got %h expected %h", obs, mk_exp(1, 0, 0, 1));
        end
        tick();
        tests++;
        if (obs !== mk_exp(2, 0, 1, 1)) begin
            fails++;
            $display("FAIL speedup_next got %h expected %h", obs, mk_exp(2, 0, 1, 1));
        end
        tick();
        bus.status = 2'd0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            tests++;
            if (obs !== mk_exp(2, 0, 0, 1)) begin
                fails++;
                $display("FAIL slowdown_idle e%0d got %h expected %h", e, obs, mk_exp(2, 0, 0, 1));
            end
        end
        tick();
        tests++;
        if (obs !== mk_exp(3, 0, 1, 1)) begin
            fails++;
            $display("FAIL slowdown_step got %h expected %h", obs, mk_exp(3, 0, 1, 1));
        end
    endtask

    task automatic test_pause();
        apply_reset(2'd1, 1'b0);
        for (int e = 1; e <= 6; e++) tick();
        tests++;
        if (obs !== mk_exp(1, 0, 0, 1)) begin
            fails++;
            $display("FAIL pause_setup got %h expected %h", obs, mk_exp(1, 0, 0, 1));
        end
        bus.status = 2'd3;
        for (int e = 1; e <= 20; e++) begin
            tick();
            tests++;
            if (obs !== mk_exp(1, 0, 0, 0)) begin
                fails++;
                $display("FAIL pause_hold e%0d got %h expected %h", e, obs, mk_exp(1, 0, 0, 0));
            end
        end
        bus.status = 2'd1;
        tick();
        tests++;
        if (obs !== mk_exp(1, 0, 0, 1)) begin
            fails++;
            $display("FAIL resume_idle got %h expected %h", obs, mk_exp(1, 0, 0, 1));
        end
        tick();
        tests++;
        if (obs !== mk_exp(2, 0, 1, 1)) begin
            fails++;
            $display("FAIL resume_step got %h expected %h", obs, mk_exp(2, 0, 1, 1));
        end
    endtask

    task automatic test_rotate();
        int rot_pos [3] = '{7, 0, 1};
        apply_reset(2'd2, 1'b1);
        for (int e = 1; e <= 12; e++) tick();
        tests++;
        if (obs !== mk_exp(6, 0, 1, 1)) begin
            fails++;
            $display("FAIL rotate_setup got %h expected %h", obs, mk_exp(6, 0, 1, 1));
        end
        for (int s = 0; s < 3; s++) begin
            tick();
            tick();
            tests++;
            if (obs !== mk_exp(rot_pos[s], 0, 1, 1)) begin
                fails++;
                $display("FAIL rotate_step s%0d got %h expected %h", s, obs, mk_exp(rot_pos[s], 0, 1, 1));
            end
        end
        apply_reset(2'd2, 1'b0);
        for (int e = 1; e <= 18; e++) tick();
        tests++;
        if (obs !== mk_exp(5, 1, 1, 1)) begin
            fails++;
            $display("FAIL bounce_to_rotate_setup got %h expected %h", obs, mk_exp(5, 1, 1, 1));
        end
        bus.mode = 1'b1;
        tick();
        tests++;
        if (obs !== mk_exp(5, 1, 0, 1)) begin
            fails++;
            $display("FAIL bounce_to_rotate_idle got %h expected %h", obs, mk_exp(5, 1, 0, 1));
        end
        tick();
        tests++;
        if (obs !== mk_exp(6, 0, 1, 1)) begin
            fails++;
            $display("FAIL bounce_to_rotate_step got %h expected %h", obs, mk_exp(6, 0, 1, 1));
        end
    endtask

    task automatic test_async_reset();
        apply_reset(2'd1, 1'b0);
        for (int e = 1; e <= 23; e++) tick();
        tests++;
        if (obs !== mk_exp(5, 0, 0, 1)) begin
            fails++;
            $display("FAIL async_setup got %h expected %h", obs, mk_exp(5, 0, 0, 1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== mk_exp(0, 0, 0, 0)) begin
            fails++;
            $display("FAIL async_reset got %h expected %h", obs, mk_exp(0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_first_steps("after_async");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.status = 2'd1;
        bus.mode   = 1'b0;
        test_reset();
        test_first_step();
        test_bounce();
        test_speed_change();
        test_pause();
        test_rotate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
